// File: rtl/mem_loader.sv
// Write-side front end for the instruction memory: captures switch words on Wr key edges
// and writes them at sequential addresses. Optional checksum output under MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              MClock,
  input  logic              Reset,
  input  logic              Wr,
  input  logic              Finish,
  input  logic [DATA_W-1:0] DIn,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DOut,
  output logic              WrEn,
  output logic [ADDR_W:0]   Count,
  output logic              Loaded,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] Sum,
`endif
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state, w_next_state;
  logic                r_wr_q, r_finish_q;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_dout, w_dout;
  logic                r_wren, w_wren;
  logic [ADDR_W:0]     r_count, w_count;
  logic                r_loaded, w_loaded;
  logic                r_pend, w_pend;
  logic [DATA_W-1:0]   r_sum, w_sum;
  logic                w_wr_edge, w_fin_edge;

  assign w_wr_edge  = Wr & ~r_wr_q;
  assign w_fin_edge = Finish & ~r_finish_q;

  always_comb begin
    w_next_state = r_state;
    w_addr       = r_addr;
    w_dout       = r_dout;
    w_wren       = 1'b0;
    w_count      = r_count;
    w_loaded     = r_loaded;
    w_pend       = r_pend;
    w_sum        = r_sum;
    case (r_state)
      S_IDLE: begin
        // A write wins over a simultaneous finish; the finish is remembered.
        if (w_wr_edge) begin
          w_dout       = DIn;
          w_wren       = 1'b1;
          w_pend       = r_pend | w_fin_edge;
          w_next_state = S_WRITE;
        end else if (w_fin_edge) begin
          w_next_state = S_DONE;
        end
      end
      S_WRITE: begin
        w_addr  = r_addr + ADDR_W'(1);
        w_count = r_count + (ADDR_W+1)'(1);
        w_sum   = r_sum + r_dout;
        w_pend  = r_pend | w_fin_edge;
        if ((w_count == LP_DEPTH) || w_pend) w_next_state = S_DONE;
        else                                 w_next_state = S_IDLE;
      end
      S_DONE: begin
        w_addr   = '0;
        w_loaded = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Edge registers reset high so a key held through reset release is not seen as a press.
  always_ff @(posedge MClock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_wr_q     <= 1'b1;
      r_finish_q <= 1'b1;
      r_addr     <= '0;
      r_dout     <= '0;
      r_wren     <= 1'b0;
      r_count    <= '0;
      r_loaded   <= 1'b0;
      r_pend     <= 1'b0;
      r_sum      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wr_q     <= Wr;
      r_finish_q <= Finish;
      r_addr     <= w_addr;
      r_dout     <= w_dout;
      r_wren     <= w_wren;
      r_count    <= w_count;
      r_loaded   <= w_loaded;
      r_pend     <= w_pend;
      r_sum      <= w_sum;
    end
  end

  assign Addr     = r_addr;
  assign DOut     = r_dout;
  assign WrEn     = r_wren;
  assign Count    = r_count;
  assign Loaded   = r_loaded;
  assign DbgState = r_state;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign Sum      = r_sum;
`else
  logic w_unused_sum;
  assign w_unused_sum = ^r_sum;
`endif

endmodule
